// File: rtl/synapse_sum_sequencer_if.sv
// Request/result bundle between the spike/weight registers and the
// time-multiplexed synapse weight summer.
interface synapse_sum_sequencer_if #(
  parameter int P_INPUT_WIDTH = 16
);
  logic                          i_start;
  logic                          i_abort;
  logic [41:0]                   i_spikes;
  logic [42*P_INPUT_WIDTH-1:0]   i_weights;
  logic                          o_ready;
  logic                          o_valid;
  logic [P_INPUT_WIDTH+5:0]      o_sum;
  logic [5:0]                    o_count;

  modport master (
    output i_start, i_abort, i_spikes, i_weights,
    input  o_ready, o_valid, o_sum, o_count
  );

  modport slave (
    input  i_start, i_abort, i_spikes, i_weights,
    output o_ready, o_valid, o_sum, o_count
  );
endinterface

// File: rtl/synapse_sum_sequencer.sv
// Sums the weights of active synapses (42 inputs) through one 4-lane adder,
// 11 groups per transaction, and reports the total with a one-cycle valid pulse.
module synapse_sum_sequencer #(
  parameter int P_INPUT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  synapse_sum_sequencer_if.slave bus
);
  localparam int W      = P_INPUT_WIDTH;
  localparam int N_LANE = 4;
  localparam int N_PAD  = 44;
  localparam logic [3:0] LP_LAST_GRP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [3:0]           r_grp;
  logic [N_PAD-1:0]     r_spikes;
  logic [N_PAD*W-1:0]   r_weights;
  logic [W+5:0]         r_acc;
  logic [5:0]           r_cnt;
  logic                 r_ready;
  logic                 r_valid;
  logic [W+5:0]         r_sum;
  logic [5:0]           r_count;

  logic [W+1:0]         w_lane_sum;
  logic [2:0]           w_lane_pop;
  logic [W+5:0]         w_acc_nxt;
  logic [5:0]           w_cnt_nxt;

  // Captured operands are padded to 44 entries and shifted down one group per
  // ACC cycle, so the lanes always read the low four slots; lanes 2/3 of the
  // last group are additionally masked.
  always_comb begin
    w_lane_sum = '0;
    w_lane_pop = '0;
    for (int unsigned l = 0; l < N_LANE; l++) begin
      if (r_spikes[l] && (r_grp != LP_LAST_GRP || l < 2)) begin
        w_lane_sum = w_lane_sum + {2'b00, r_weights[l*W +: W]};
        w_lane_pop = w_lane_pop + 3'd1;
      end
    end
    w_acc_nxt = r_acc + {4'b0000, w_lane_sum};
    w_cnt_nxt = r_cnt + {3'b000, w_lane_pop};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grp     <= '0;
      r_spikes  <= '0;
      r_weights <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (bus.i_start && !bus.i_abort) begin
            r_spikes  <= {2'b00, bus.i_spikes};
            r_weights <= {{(2*W){1'b0}}, bus.i_weights};
            r_acc     <= '0;
            r_cnt     <= '0;
            r_grp     <= '0;
            r_ready   <= 1'b0;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          if (bus.i_abort) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_spikes  <= r_spikes >> N_LANE;
            r_weights <= r_weights >> (N_LANE*W);
            r_grp     <= r_grp + 4'd1;
            if (r_grp == LP_LAST_GRP) begin
              r_sum   <= w_acc_nxt;
              r_count <= w_cnt_nxt;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_sum   = r_sum;
  assign bus.o_count = r_count;
endmodule

// File: tb/tb_synapse_sum_sequencer.sv
// Directed bench for synapse_sum_sequencer: latency, masking, abort, reset,
// input isolation after acceptance and start/abort collisions.
module tb_synapse_sum_sequencer;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  synapse_sum_sequencer_if #(.P_INPUT_WIDTH(W)) bus ();

  synapse_sum_sequencer #(.P_INPUT_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start at the edge ending cycle N; the k-th negedge after that edge lies in cycle N+k.
  task automatic run_txn(input string name, input logic [41:0] spk,
                         input logic [42*W-1:0] wts, input logic [21:0] exp_sum,
                         input logic [5:0] exp_cnt, input bit scramble);
    logic early;
    @(negedge clk);
    chk({name, "_ready_before"}, {31'b0, bus.o_ready}, 32'd1);
    bus.i_start   = 1'b1;
    bus.i_spikes  = spk;
    bus.i_weights = wts;
    early = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) chk({name, "_ready_busy"}, {31'b0, bus.o_ready}, 32'd0);
      if (bus.o_valid) early = 1'b1;
      if (scramble && j <= 10) begin
        bus.i_start   = $urandom_range(0, 1) == 1;
        bus.i_spikes  = {$urandom(), $urandom()};
        for (int k = 0; k < 42; k++) bus.i_weights[k*W +: W] = W'($urandom());
      end else begin
        bus.i_start = 1'b0;
      end
    end
    chk({name, "_no_early_valid"}, {31'b0, early}, 32'd0);
    @(negedge clk);
    chk({name, "_valid_n12"}, {31'b0, bus.o_valid}, 32'd1);
    chk({name, "_sum"},   {10'b0, bus.o_sum}, {10'b0, exp_sum});
    chk({name, "_count"}, {26'b0, bus.o_count}, {26'b0, exp_cnt});
    @(negedge clk);
    chk({name, "_valid_drop"}, {31'b0, bus.o_valid}, 32'd0);
    chk({name, "_ready_n13"}, {31'b0, bus.o_ready}, 32'd1);
  endtask

  logic [42*W-1:0] wv;
  logic [41:0]     sv;
  logic            seen;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_spikes  = '0;
    bus.i_weights = '0;
    #12;
    chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rst_sum",   {10'b0, bus.o_sum}, 32'd0);
    chk("rst_count", {26'b0, bus.o_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ones: 42 * 0xFFFF = 0x29FFD6
    wv = '1;
    run_txn("full", '1, wv, 22'h29FFD6, 6'd42, 1'b0);

    wv = '1;
    wv[41*W +: W] = 16'h1234;
    run_txn("spk41", 42'h200_0000_0000, wv, 22'h001234, 6'd1, 1'b0);

    wv = '1;
    wv[0 +: W] = 16'h0001;
    run_txn("spk0", 42'h1, wv, 22'h000001, 6'd1, 1'b0);

    for (int k = 0; k < 42; k++) wv[k*W +: W] = 16'hABCD;
    run_txn("zero", '0, wv, 22'h0, 6'd0, 1'b0);

    // Mixed: spikes 0,5,10,40,41 with weight k = 0x1000+k -> 0x5000+96 = 0x5060
    for (int k = 0; k < 42; k++) wv[k*W +: W] = 16'h1000 + 16'(k);
    sv = '0;
    sv[0] = 1'b1; sv[5] = 1'b1; sv[10] = 1'b1; sv[40] = 1'b1; sv[41] = 1'b1;
    run_txn("mixed", sv, wv, 22'h005060, 6'd5, 1'b0);

    // Abort sampled on the edge ending cycle N+5
    @(negedge clk);
    bus.i_start = 1'b1;
    wv = '1;
    bus.i_spikes  = '1;
    bus.i_weights = wv;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (j == 5) bus.i_abort = 1'b1;
    end
    @(negedge clk);
    bus.i_abort = 1'b0;
    chk("abort_ready_n6", {31'b0, bus.o_ready}, 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'b0, seen}, 32'd0);
    chk("abort_sum_held", {10'b0, bus.o_sum}, 32'h005060);
    chk("abort_count_held", {26'b0, bus.o_count}, 32'd5);

    // Lower 21 spikes, weights 0x0100 -> 21*256 = 0x1500
    for (int k = 0; k < 42; k++) wv[k*W +: W] = 16'h0100;
    run_txn("after_abort", 42'h1F_FFFF, wv, 22'h001500, 6'd21, 1'b0);

    // Spikes 1..3 with weight k = 0x10*k -> 0x10+0x20+0x30 = 0x60; inputs scrambled during ACC
    for (int k = 0; k < 42; k++) wv[k*W +: W] = 16'(16 * k);
    run_txn("scramble", 42'hE, wv, 22'h000060, 6'd3, 1'b1);
    seen = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (bus.o_valid || !bus.o_ready) seen = 1'b1;
    end
    chk("scramble_no_extra_txn", {31'b0, seen}, 32'd0);

    // Start and abort together in IDLE: start dropped
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("collide_ready", {31'b0, bus.o_ready}, 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (bus.o_valid || !bus.o_ready) seen = 1'b1;
    end
    chk("collide_no_txn", {31'b0, seen}, 32'd0);

    // Reset asserted in cycle N+7
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_spikes  = '1;
    bus.i_weights = '1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("midrst_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("midrst_sum",   {10'b0, bus.o_sum}, 32'd0);
    chk("midrst_count", {26'b0, bus.o_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", {31'b0, seen}, 32'd0);

    for (int k = 0; k < 42; k++) wv[k*W +: W] = 16'h0001;
    run_txn("post_rst", '1, wv, 22'd42, 6'd42, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
